// File: rtl/vga_tile_arbiter_if.sv
// Host write port of the tile arbiter.
// The host (master) raises wr_req with wr_addr/wr_data and holds them until
// the arbiter (slave) answers with a one-cycle wr_ack. wr_err accompanies
// wr_ack when the address is outside the 25-entry tile RAM.
//   wr_req   host -> arbiter  write request, held until wr_ack
//   wr_addr  host -> arbiter  tile index row*GRID+col
//   wr_data  host -> arbiter  {r,g,b} colour, 4 bits each
//   wr_ack   arbiter -> host  request consumed this cycle
//   wr_err   arbiter -> host  request consumed but address out of range
interface vga_tile_arbiter_if;
  logic        wr_req;
  logic [4:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        wr_err;

  modport master (output wr_req, output wr_addr, output wr_data,
                  input  wr_ack, input  wr_err);
  modport slave  (input  wr_req, input  wr_addr, input  wr_data,
                  output wr_ack, output wr_err);
endinterface

// File: rtl/vga_tile_arbiter.sv
// VGA tile arbiter: generates 800x600 timing from the pixel clock, shows a
// 5x5 grid of solid-colour tiles and shares the single-port tile RAM between
// scanout (fixed priority) and a host writer.
//   clk          pixel clock, rising edge
//   rst_n        asynchronous active-low reset
//   host         host write handshake (slave side)
//   mem_addr     RAM address
//   mem_we       RAM write enable
//   mem_wdata    RAM write data
//   mem_rdata    RAM read data, one cycle after mem_addr
//   r, g, b      colour outputs, registered
//   h_sync       horizontal sync, registered
//   v_sync       vertical sync, registered
//   frame_start  one-cycle pulse registered from h=0,v=0
module vga_tile_arbiter #(
  parameter int H_TOTAL      = 1040,
  parameter int H_SYNC_START = 56,
  parameter int H_SYNC_END   = 176,
  parameter int H_VIS_START  = 240,
  parameter int V_TOTAL      = 666,
  parameter int V_SYNC_START = 37,
  parameter int V_SYNC_END   = 43,
  parameter int V_VIS_START  = 66,
  parameter int TILE_W       = 160,
  parameter int TILE_H       = 120,
  parameter int GRID         = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_tile_arbiter_if.slave     host,
  output logic [4:0]            mem_addr,
  output logic                  mem_we,
  output logic [11:0]           mem_wdata,
  input  logic [11:0]           mem_rdata,
  output logic [3:0]            r,
  output logic [3:0]            g,
  output logic [3:0]            b,
  output logic                  h_sync,
  output logic                  v_sync,
  output logic                  frame_start
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW = $clog2(TILE_W);
  localparam int RW = $clog2(TILE_H);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_FETCH0 = HW'(H_VIS_START - 2);
  localparam logic [HW-1:0] H_PRE    = HW'(H_VIS_START - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VIS_START);
  localparam logic [HW-1:0] H_SS     = HW'(H_SYNC_START);
  localparam logic [HW-1:0] H_SE     = HW'(H_SYNC_END);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VIS_START);
  localparam logic [VW-1:0] V_SS     = VW'(V_SYNC_START);
  localparam logic [VW-1:0] V_SE     = VW'(V_SYNC_END);
  localparam logic [CW-1:0] C_LAST   = CW'(TILE_W - 1);
  localparam logic [CW-1:0] C_FETCH  = CW'(TILE_W - 2);
  localparam logic [RW-1:0] R_LAST   = RW'(TILE_H - 1);
  localparam logic [4:0]    K_LAST   = 5'(GRID - 1);
  localparam logic [4:0]    GRID5    = 5'(GRID);
  localparam logic [4:0]    TILES    = 5'(GRID * GRID);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [CW-1:0] col_cnt;
  logic [4:0]    col;
  logic [RW-1:0] row_cnt;
  logic [4:0]    row_base;
  logic [11:0]   pix;
  logic          fetch_d;

  logic          h_vis;
  logic          v_vis;
  logic          visible;
  logic          fetch;
  logic [4:0]    fetch_addr;
  logic          addr_bad;
  logic          grant;

  assign h_vis   = (h >= H_VIS);
  assign v_vis   = (v >= V_VIS);
  assign visible = h_vis && v_vis;

  // Fetch slots sit two cycles ahead of each tile boundary: one cycle for the
  // synchronous RAM read, one to load the pixel register. The first slot of a
  // line lies in blanking; later ones are found from the displayed tile's
  // intra-tile counter so no division of h is needed.
  always_comb begin
    fetch      = 1'b0;
    fetch_addr = row_base;
    if (v_vis) begin
      if (h == H_FETCH0) begin
        fetch      = 1'b1;
        fetch_addr = row_base;
      end else if (h_vis && (col_cnt == C_FETCH) && (col != K_LAST)) begin
        fetch      = 1'b1;
        fetch_addr = row_base + col + 5'd1;
      end
    end
  end

  assign addr_bad  = (host.wr_addr >= TILES);
  assign grant     = rst_n && host.wr_req && !fetch;
  assign mem_wdata = host.wr_data;

  // Scanout owns the RAM in a fetch slot; any other cycle goes to the writer.
  // An out-of-range request is still acknowledged so the host never stalls.
  always_comb begin
    mem_we      = 1'b0;
    mem_addr    = 5'd0;
    host.wr_ack = 1'b0;
    host.wr_err = 1'b0;
    if (fetch) begin
      mem_addr = fetch_addr;
    end else if (grant) begin
      host.wr_ack = 1'b1;
      if (addr_bad) begin
        host.wr_err = 1'b1;
      end else begin
        mem_we   = 1'b1;
        mem_addr = host.wr_addr;
      end
    end
  end

  // Raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= (h == H_LAST) ? '0 : h + HW'(1);
      if (h == H_LAST) begin
        v <= (v == V_LAST) ? '0 : v + VW'(1);
      end
    end
  end

  // Tile column tracking: restarts just before the first visible pixel so
  // col_cnt is 0 on the first pixel of each tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      col     <= '0;
    end else if (h == H_PRE) begin
      col_cnt <= '0;
      col     <= '0;
    end else if (h_vis) begin
      if (col_cnt == C_LAST) begin
        col_cnt <= '0;
        col     <= col + 5'd1;
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  // Tile row tracking: row_base holds row*GRID so the fetch address is a sum.
  // Frame wrap takes precedence over the row rollover on the last line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      row_base <= '0;
    end else if (h == H_LAST) begin
      if (v == V_LAST) begin
        row_cnt  <= '0;
        row_base <= '0;
      end else if (v_vis) begin
        if (row_cnt == R_LAST) begin
          row_cnt  <= '0;
          row_base <= row_base + GRID5;
        end else begin
          row_cnt <= row_cnt + RW'(1);
        end
      end
    end
  end

  // Pixel register loads the read data the cycle after a fetch slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_d <= 1'b0;
      pix     <= '0;
    end else begin
      fetch_d <= fetch;
      if (fetch_d) begin
        pix <= mem_rdata;
      end
    end
  end

  // All display outputs share one register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      g           <= '0;
      b           <= '0;
      h_sync      <= 1'b0;
      v_sync      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r           <= visible ? pix[11:8] : 4'd0;
      g           <= visible ? pix[7:4]  : 4'd0;
      b           <= visible ? pix[3:0]  : 4'd0;
      h_sync      <= (h >= H_SS) && (h < H_SE);
      v_sync      <= (v >= V_SS) && (v < V_SE);
      frame_start <= (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_vga_tile_arbiter.sv
// Testbench for vga_tile_arbiter with scaled-down raster timing so several
// whole frames fit in a short run. Random host traffic is checked cycle by
// cycle against a model derived from a free-running cycle count: h and v come
// from modulo arithmetic, a shadow tile RAM tracks accepted writes, and each
// fetch snapshots the shadow for the tile about to be displayed.
module tb_vga_tile_arbiter;

  localparam int TH   = 40;
  localparam int THSS = 2;
  localparam int THSE = 6;
  localparam int THVS = 10;
  localparam int TV   = 25;
  localparam int TVSS = 1;
  localparam int TVSE = 3;
  localparam int TVVS = 5;
  localparam int TW   = 6;
  localparam int TTH  = 4;
  localparam int TG   = 5;
  localparam int FRAME = TH * TV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [3:0]  r, g, b;
  logic        h_sync, v_sync, frame_start;

  vga_tile_arbiter_if host_if ();

  vga_tile_arbiter #(
    .H_TOTAL(TH), .H_SYNC_START(THSS), .H_SYNC_END(THSE), .H_VIS_START(THVS),
    .V_TOTAL(TV), .V_SYNC_START(TVSS), .V_SYNC_END(TVSE), .V_VIS_START(TVVS),
    .TILE_W(TW), .TILE_H(TTH), .GRID(TG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host(host_if.slave),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .r(r), .g(g), .b(b),
    .h_sync(h_sync), .v_sync(v_sync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous-read tile RAM with a preload path used while in reset.
  logic        preload;
  logic [4:0]  pl_addr;
  logic [11:0] pl_data;
  logic [11:0] ram [0:31];

  always @(posedge clk) begin
    if (preload) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int total = 0;
  int bad   = 0;
  int t;
  int req_pct;
  bit pending;
  int p_addr;
  logic [11:0] p_data;
  logic [11:0] shadow [0:24];
  logic [11:0] tile_col [0:TG-1];
  logic [11:0] exp_rgb_n;
  bit exp_hs_n, exp_vs_n, exp_fs_n;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h t=%0d", tag, got, want, t);
    end
  endtask

  // Returns the tile column fetched in cycle tc, or -1 if tc is not a fetch slot.
  function automatic int fetchK(input int tc);
    int hh, vv, x;
    hh = tc % TH;
    vv = (tc / TH) % TV;
    if (vv < TVVS) return -1;
    x = hh + 2 - THVS;
    if (x < 0 || (x % TW) != 0 || (x / TW) >= TG) return -1;
    return x / TW;
  endfunction

  task automatic applyStimulus();
    if (!pending && ($urandom_range(99) < req_pct)) begin
      pending = 1'b1;
      p_addr  = ($urandom_range(7) == 0) ? $urandom_range(31, 25) : $urandom_range(24, 0);
      p_data  = 12'($urandom);
    end
    host_if.wr_req  = pending;
    host_if.wr_addr = pending ? 5'(p_addr) : 5'($urandom);
    host_if.wr_data = pending ? p_data : 12'($urandom);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ack"}, 32'(host_if.wr_ack), 0);
    checkOutput({tag, "_err"}, 32'(host_if.wr_err), 0);
    checkOutput({tag, "_we"}, 32'(mem_we), 0);
    checkOutput({tag, "_rgb"}, 32'({r, g, b}), 0);
    checkOutput({tag, "_hs"}, 32'(h_sync), 0);
    checkOutput({tag, "_vs"}, 32'(v_sync), 0);
    checkOutput({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  // Each iteration starts just after a rising edge of cycle t.
  task automatic runCycles(input int n);
    int k, hh, vv, faddr, exp_addr;
    bit exp_ack, exp_err, exp_we;
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      @(negedge clk);
      k = fetchK(t);
      hh = t % TH;
      vv = (t / TH) % TV;
      faddr = (k >= 0) ? ((vv - TVVS) / TTH) * TG + k : 0;
      exp_ack = pending && (k < 0);
      exp_err = exp_ack && (p_addr >= 25);
      exp_we  = exp_ack && !exp_err;
      exp_addr = (k >= 0) ? faddr : (exp_we ? p_addr : 0);
      checkOutput("wr_ack", 32'(host_if.wr_ack), 32'(exp_ack));
      checkOutput("wr_err", 32'(host_if.wr_err), 32'(exp_err));
      checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
      if (k >= 0 || exp_we || !pending)
        checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr));
      if (exp_we)
        checkOutput("mem_wdata", 32'(mem_wdata), 32'(p_data));
      if (t == 0) begin
        checkOutput("rgb0", 32'({r, g, b}), 0);
        checkOutput("hs0", 32'(h_sync), 0);
        checkOutput("vs0", 32'(v_sync), 0);
        checkOutput("fs0", 32'(frame_start), 0);
      end else begin
        checkOutput("rgb", 32'({r, g, b}), 32'(exp_rgb_n));
        checkOutput("h_sync", 32'(h_sync), 32'(exp_hs_n));
        checkOutput("v_sync", 32'(v_sync), 32'(exp_vs_n));
        checkOutput("frame_start", 32'(frame_start), 32'(exp_fs_n));
      end
      if (k >= 0) tile_col[k] = shadow[faddr];
      if (exp_we) shadow[p_addr] = p_data;
      if (exp_ack) pending = 1'b0;
      exp_hs_n  = (hh >= THSS) && (hh < THSE);
      exp_vs_n  = (vv >= TVSS) && (vv < TVSE);
      exp_fs_n  = (hh == 0) && (vv == 0);
      exp_rgb_n = (hh >= THVS && vv >= TVVS) ? tile_col[(hh - THVS) / TW] : 12'h000;
      t++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    preload = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    pending = 1'b0;
    p_addr = 0;
    p_data = '0;
    t = 0;
    req_pct = 60;
    host_if.wr_req = 1'b1;
    host_if.wr_addr = 5'd3;
    host_if.wr_data = 12'hABC;
    for (int i = 0; i < TG; i++) tile_col[i] = 12'h000;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 25; i++) begin
      #1;
      preload = 1'b1;
      pl_addr = 5'(i);
      pl_data = 12'($urandom);
      shadow[i] = pl_data;
      @(posedge clk);
    end
    #1;
    preload = 1'b0;
    @(negedge clk);
    checkReset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
    runCycles(1500);
    req_pct = 100;
    runCycles(700);
    req_pct = 70;
    runCycles(((12 * TH + 20) - (t % FRAME) + FRAME) % FRAME);
    // Mid-frame reset in the visible region with a request held.
    pending = 1'b1;
    p_addr = 9;
    p_data = 12'h5A5;
    host_if.wr_req = 1'b1;
    host_if.wr_addr = 5'd9;
    host_if.wr_data = 12'h5A5;
    rst_n = 1'b0;
    #1;
    checkReset("midreset");
    repeat (3) begin
      @(negedge clk);
      checkReset("inreset");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
    runCycles(1300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
